// File: rtl/ifu_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ifu_pkg
// Shared definitions for the instruction fetch unit:
//   - IFU_START_PC   : default architectural PC loaded on reset
//   - IFU_RST_ACTIVE : level of the synchronous reset that clears state
//   - ifu_state_e    : fetch FSM state encodings (IDLE/REQ/WAIT/DROP)
// ---------------------------------------------------------------------------
package ifu_pkg;

  localparam logic [63:0] IFU_START_PC   = 64'h0000_0000_8000_0000;
  localparam logic        IFU_RST_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no request, waiting for queue credit
    ST_REQ  = 2'd1,  // request presented to instruction memory
    ST_WAIT = 2'd2,  // request accepted, response pending
    ST_DROP = 2'd3   // response pending but stale after a flush
  } ifu_state_e;

endpackage

// File: rtl/ifu_fetch_unit_queue.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ifu_fetch_queue
// Synchronous FIFO holding {pc, instruction} pairs between the instruction
// memory response and the decode stage. Storage is registered, so the head
// output has no combinational path from the push side.
// Ports:
//   clk, rst         : clock, synchronous active-low reset
//   i_push/i_push_data : write one entry
//   i_pop            : consume the head entry (ignored when empty)
//   i_flush          : discard every entry; overrides push and pop
//   o_head           : head entry
//   o_count          : number of valid entries (log2(DEPTH)+1 bits)
//   o_full/o_empty   : occupancy flags
// ---------------------------------------------------------------------------
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int               PW       = $clog2(DEPTH);
  localparam logic [PW-1:0]    PTR_INC  = PW'(1);
  localparam logic [PW:0]      CNT_INC  = (PW + 1)'(1);
  localparam logic [PW:0]      CNT_FULL = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push_en;
  logic             w_pop_en;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_FULL);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A pop from an empty queue is a no-op; a push into a full queue is only
  // accepted when the head leaves in the same cycle.
  assign w_pop_en  = i_pop & ~o_empty;
  assign w_push_en = i_push & (~o_full | w_pop_en);

  // Storage, pointer and occupancy update; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst == IFU_RST_ACTIVE) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_INC;
      end
      if (w_pop_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_INC;
      end
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + CNT_INC;
        2'b01:   r_count <= r_count - CNT_INC;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ifu_fetch_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ifu_fetch_unit
// Owns the architectural fetch PC, issues at most one outstanding request on
// a valid/ready instruction-memory port, buffers responses in a fetch queue
// and hands them to decode with a valid/ready handshake. A trap or branch
// redirect flushes queued and in-flight fetches and restarts at the target.
// Ports:
//   clk, rst                   : clock, synchronous active-low reset
//   trap_valid_i/trap_pc_i     : trap redirect (highest priority)
//   br_valid_i/br_pc_i         : branch/jump redirect
//   imem_req_valid_o/_ready_i  : request handshake
//   imem_addr_o                : request address
//   imem_resp_valid_i/_data_i  : instruction response
//   inst_valid_o/inst_ready_i  : decode handshake
//   inst_o/inst_pc_o           : head instruction and its PC
// ---------------------------------------------------------------------------
module ifu_fetch_unit
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              INST_W   = 32,
  parameter logic [XLEN-1:0] START_PC = XLEN'(IFU_START_PC),
  parameter int              FQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_valid_i,
  input  logic [XLEN-1:0]   trap_pc_i,
  input  logic              br_valid_i,
  input  logic [XLEN-1:0]   br_pc_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [XLEN-1:0]   imem_addr_o,
  input  logic              imem_resp_valid_i,
  input  logic [INST_W-1:0] imem_resp_data_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [XLEN-1:0]   inst_pc_o
);

  localparam int              CW         = $clog2(FQ_DEPTH) + 1;
  localparam int              QW         = XLEN + INST_W;
  localparam logic [XLEN-1:0] PC_INC     = XLEN'(INST_W / 8);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(2'b11));
  localparam logic [CW-1:0]   CNT_FULL   = CW'(FQ_DEPTH);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1);

  ifu_state_e       r_state;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_req_pc;
  logic [XLEN-1:0]  r_addr;
  logic             r_req_valid;

  logic             w_redirect;
  logic [XLEN-1:0]  w_target_raw;
  logic [XLEN-1:0]  w_target;
  logic             w_hs;
  logic             w_push;
  logic             w_pop;
  logic [QW-1:0]    w_push_data;
  logic [QW-1:0]    w_head;
  logic [CW-1:0]    w_fq_count;
  logic [CW-1:0]    w_count_next;
  logic             w_fq_full;
  logic             w_fq_empty;
  logic             w_credit_idle;
  logic             w_credit_wait;

  // Redirect target selection: trap wins over branch.
  always_comb begin
    w_target_raw = br_pc_i;
    if (trap_valid_i) begin
      w_target_raw = trap_pc_i;
    end else begin
      w_target_raw = br_pc_i;
    end
  end

  assign w_redirect = trap_valid_i | br_valid_i;
  assign w_target   = w_target_raw & ALIGN_MASK;

  assign w_hs        = r_req_valid & imem_req_ready_i;
  assign w_pop       = inst_valid_o & inst_ready_i;
  // A response arriving together with a redirect belongs to the old stream.
  assign w_push      = (r_state == ST_WAIT) & imem_resp_valid_i & ~w_redirect;
  assign w_push_data = {r_req_pc, imem_resp_data_i};

  // Occupancy after this cycle's push/pop, used for the credit check that
  // decides whether a new request may follow a response.
  always_comb begin
    w_count_next = w_fq_count;
    if (w_push && !w_pop) begin
      w_count_next = w_fq_count + CNT_ONE;
    end else if (!w_push && w_pop) begin
      w_count_next = w_fq_count - CNT_ONE;
    end else begin
      w_count_next = w_fq_count;
    end
  end

  assign w_credit_idle = (w_fq_count < CNT_FULL);
  assign w_credit_wait = (w_count_next < CNT_FULL);

  ifu_fetch_queue #(
    .WIDTH (QW),
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (w_redirect),
    .o_head      (w_head),
    .o_count     (w_fq_count),
    .o_full      (w_fq_full),
    .o_empty     (w_fq_empty)
  );

  assign inst_valid_o     = ~w_fq_empty;
  assign inst_o           = w_head[INST_W-1:0];
  assign inst_pc_o        = w_head[QW-1:INST_W];
  assign imem_req_valid_o = r_req_valid;
  assign imem_addr_o      = r_addr;

  // Fetch FSM with registered request outputs. r_addr always mirrors r_pc
  // while in REQ so the address is stable while the memory stalls.
  always_ff @(posedge clk) begin
    if (rst == IFU_RST_ACTIVE) begin
      r_state     <= ST_IDLE;
      r_pc        <= START_PC;
      r_req_pc    <= '0;
      r_addr      <= '0;
      r_req_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_redirect) begin
            r_pc        <= w_target;
            r_addr      <= w_target;
            r_req_valid <= 1'b1;
            r_state     <= ST_REQ;
          end else if (w_credit_idle) begin
            r_addr      <= r_pc;
            r_req_valid <= 1'b1;
            r_state     <= ST_REQ;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_REQ: begin
          if (w_hs) begin
            r_req_pc    <= r_pc;
            r_req_valid <= 1'b0;
            if (w_redirect) begin
              // The accepted request is stale; its response must be eaten.
              r_pc    <= w_target;
              r_state <= ST_DROP;
            end else begin
              r_pc    <= r_pc + PC_INC;
              r_state <= ST_WAIT;
            end
          end else if (w_redirect) begin
            r_pc    <= w_target;
            r_addr  <= w_target;
            r_state <= ST_REQ;
          end else begin
            r_state <= ST_REQ;
          end
        end

        ST_WAIT: begin
          if (w_redirect) begin
            r_pc <= w_target;
            if (imem_resp_valid_i) begin
              // The outstanding response is already here; discard it now.
              r_addr      <= w_target;
              r_req_valid <= 1'b1;
              r_state     <= ST_REQ;
            end else begin
              r_state <= ST_DROP;
            end
          end else if (imem_resp_valid_i) begin
            if (w_credit_wait) begin
              r_addr      <= r_pc;
              r_req_valid <= 1'b1;
              r_state     <= ST_REQ;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_state <= ST_WAIT;
          end
        end

        ST_DROP: begin
          if (imem_resp_valid_i) begin
            // Queue was flushed on entry, so credit is always available.
            r_req_valid <= 1'b1;
            r_state     <= ST_REQ;
            if (w_redirect) begin
              r_pc   <= w_target;
              r_addr <= w_target;
            end else begin
              r_addr <= r_pc;
            end
          end else if (w_redirect) begin
            r_pc    <= w_target;
            r_state <= ST_DROP;
          end else begin
            r_state <= ST_DROP;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch_unit.sv
`timescale 1ns/1ps
// Self-checking bench for ifu_fetch_unit: directed vector table for the
// post-reset request/response timing, hand-written redirect/stall/reset
// sequences, and a randomized run checked against a stream-level model
// (the decode side must see consecutive PCs from the last reset/redirect
// target, each paired with the data the memory returned for that address).
module tb_ifu_fetch_unit;

  localparam logic [63:0] START = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst;
  logic        trap_valid_i;
  logic [63:0] trap_pc_i;
  logic        br_valid_i;
  logic [63:0] br_pc_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [63:0] imem_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;

  ifu_fetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .trap_valid_i      (trap_valid_i),
    .trap_pc_i         (trap_pc_i),
    .br_valid_i        (br_valid_i),
    .br_pc_i           (br_pc_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_addr_o       (imem_addr_o),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_data_i  (imem_resp_data_i),
    .inst_valid_o      (inst_valid_o),
    .inst_ready_i      (inst_ready_i),
    .inst_o            (inst_o),
    .inst_pc_o         (inst_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  int          hs_count;
  int          pop_count;
  int          lat_min;
  int          lat_max;
  logic [63:0] exp_pc;
  bit          mem_pend;
  int          mem_cnt;
  logic [63:0] mem_addr;

  typedef struct {
    logic        req_v;
    logic [63:0] addr;
    logic        inst_v;
    logic [63:0] ipc;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: model bookkeeping from pre-edge values, edge, memory model,
  // then post-edge protocol checks.
  task automatic step();
    logic        pre_hs, pre_pop, pre_redir, pre_rst, pre_stall;
    logic [63:0] pre_addr, pre_tgt;
    pre_hs    = imem_req_valid_o & imem_req_ready_i;
    pre_pop   = inst_valid_o & inst_ready_i;
    pre_redir = trap_valid_i | br_valid_i;
    pre_tgt   = (trap_valid_i ? trap_pc_i : br_pc_i) & ~64'd3;
    pre_rst   = rst;
    pre_stall = imem_req_valid_o & ~imem_req_ready_i;
    pre_addr  = imem_addr_o;
    if (pre_rst && dut.w_push && dut.w_fq_full) begin
      errors++;
      $display("FAIL push_when_full: got push=1 expected push=0");
    end
    if (pre_rst && pre_hs && mem_pend) begin
      errors++;
      $display("FAIL two_outstanding: got 2 expected 1");
    end
    if (pre_rst && pre_pop && !pre_redir) begin
      chk("inst_pc", inst_pc_o, exp_pc);
      chk("inst_data", 64'(inst_o), 64'(mem_data(inst_pc_o)));
      exp_pc    = exp_pc + 64'd4;
      pop_count++;
    end
    if (pre_rst && pre_hs) hs_count++;
    if (!pre_rst) exp_pc = START;
    else if (pre_redir) exp_pc = pre_tgt;

    @(posedge clk);
    #1;

    imem_resp_valid_i = 1'b0;
    if (!pre_rst) begin
      mem_pend = 1'b0;
    end else begin
      if (pre_hs) begin
        mem_pend = 1'b1;
        mem_addr = pre_addr;
        mem_cnt  = int'($urandom_range(lat_max, lat_min));
      end
      if (mem_pend) begin
        if (mem_cnt <= 1) begin
          imem_resp_valid_i = 1'b1;
          imem_resp_data_i  = mem_data(mem_addr);
          mem_pend          = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
    end

    if (pre_rst && pre_redir) chk("flush_empties", 64'(inst_valid_o), 64'd0);
    if (pre_rst && pre_stall && !pre_redir) begin
      chk("req_hold_valid", 64'(imem_req_valid_o), 64'd1);
      chk("req_hold_addr", imem_addr_o, pre_addr);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    trap_valid_i = 1'b0;
    br_valid_i   = 1'b0;
    step();
    step();
    chk("rst_req_valid", 64'(imem_req_valid_o), 64'd0);
    chk("rst_addr", imem_addr_o, 64'd0);
    chk("rst_inst_valid", 64'(inst_valid_o), 64'd0);
    chk("rst_inst", 64'(inst_o), 64'd0);
    chk("rst_inst_pc", inst_pc_o, 64'd0);
    rst = 1'b1;
    hs_count  = 0;
    pop_count = 0;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!imem_req_valid_o && n < 50) begin
      step();
      n++;
    end
    chk(name, 64'(imem_req_valid_o), 64'd1);
  endtask

  task automatic wait_inst(input string name);
    int n;
    n = 0;
    while (!inst_valid_o && n < 50) begin
      step();
      n++;
    end
    chk(name, 64'(inst_valid_o), 64'd1);
  endtask

  initial begin
    logic [63:0] first;
    logic [63:0] tgt;
    int          n;
    checks = 0; errors = 0; hs_count = 0; pop_count = 0;
    exp_pc = START; mem_pend = 1'b0; mem_cnt = 0; mem_addr = 64'd0;
    rst = 1'b0; trap_valid_i = 1'b0; trap_pc_i = 64'd0;
    br_valid_i = 1'b0; br_pc_i = 64'd0;
    imem_req_ready_i = 1'b1; imem_resp_valid_i = 1'b0; imem_resp_data_i = 32'd0;
    inst_ready_i = 1'b1; lat_min = 1; lat_max = 1;

    // Post-reset timing with an always-ready, 1-cycle memory.
    tbl[0] = '{1'b1, 64'h8000_0000, 1'b0, 64'd0};
    tbl[1] = '{1'b0, 64'd0,         1'b0, 64'd0};
    tbl[2] = '{1'b1, 64'h8000_0004, 1'b1, 64'h8000_0000};
    tbl[3] = '{1'b0, 64'd0,         1'b0, 64'd0};
    tbl[4] = '{1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004};
    tbl[5] = '{1'b0, 64'd0,         1'b0, 64'd0};
    tbl[6] = '{1'b1, 64'h8000_000C, 1'b1, 64'h8000_0008};
    tbl[7] = '{1'b0, 64'd0,         1'b0, 64'd0};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("tbl%0d_req_valid", i), 64'(imem_req_valid_o), 64'(tbl[i].req_v));
      if (tbl[i].req_v) chk($sformatf("tbl%0d_addr", i), imem_addr_o, tbl[i].addr);
      chk($sformatf("tbl%0d_inst_valid", i), 64'(inst_valid_o), 64'(tbl[i].inst_v));
      if (tbl[i].inst_v) chk($sformatf("tbl%0d_inst_pc", i), inst_pc_o, tbl[i].ipc);
    end

    // Decode stalled: exactly FQ_DEPTH fetches, then drain one per cycle.
    do_reset();
    inst_ready_i = 1'b0; lat_min = 1; lat_max = 2;
    for (int i = 0; i < 30; i++) step();
    chk("full_hs_count", 64'(hs_count), 64'd4);
    chk("full_req_idle", 64'(imem_req_valid_o), 64'd0);
    chk("full_inst_valid", 64'(inst_valid_o), 64'd1);
    inst_ready_i = 1'b1; pop_count = 0;
    for (int i = 0; i < 4; i++) step();
    chk("drain_pops", 64'(pop_count), 64'd4);
    for (int i = 0; i < 20; i++) step();
    chk("fetch_resumes", 64'(hs_count > 4), 64'd1);

    // Branch while a response is pending with a non-empty queue.
    do_reset();
    inst_ready_i = 1'b0; lat_min = 3; lat_max = 3;
    n = 0;
    while (!(mem_pend && inst_valid_o) && n < 50) begin
      step();
      n++;
    end
    chk("br_setup", 64'(mem_pend && inst_valid_o), 64'd1);
    br_valid_i = 1'b1; br_pc_i = 64'h8000_0100;
    step();
    br_valid_i = 1'b0;
    chk("br_queue_empty", 64'(inst_valid_o), 64'd0);
    wait_req("br_req_timeout");
    chk("br_req_addr", imem_addr_o, 64'h8000_0100);
    inst_ready_i = 1'b1;
    wait_inst("br_inst_timeout");
    chk("br_first_pc", inst_pc_o, 64'h8000_0100);

    // Trap and branch together: trap target wins.
    trap_valid_i = 1'b1; trap_pc_i = 64'h8000_0200;
    br_valid_i   = 1'b1; br_pc_i   = 64'h8000_0100;
    step();
    trap_valid_i = 1'b0; br_valid_i = 1'b0;
    wait_req("trap_req_timeout");
    chk("trap_req_addr", imem_addr_o, 64'h8000_0200);
    wait_inst("trap_inst_timeout");
    chk("trap_first_pc", inst_pc_o, 64'h8000_0200);

    // Memory not ready for 5 cycles: request held, one handshake, PC +4 once.
    do_reset();
    imem_req_ready_i = 1'b0; lat_min = 1; lat_max = 1;
    wait_req("stall_req_timeout");
    first = imem_addr_o;
    chk("stall_first_addr", first, 64'h8000_0000);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 64'(imem_req_valid_o), 64'd1);
      chk("stall_addr", imem_addr_o, first);
    end
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    wait_req("stall_next_timeout");
    chk("stall_next_addr", imem_addr_o, first + 64'd4);
    chk("stall_hs_count", 64'(hs_count), 64'd1);

    // Reset while waiting on the fetch at 0x8000_003C (pc = 0x8000_0040).
    do_reset();
    imem_req_ready_i = 1'b1; inst_ready_i = 1'b1; lat_min = 3; lat_max = 3;
    n = 0;
    while (!(mem_pend && mem_addr == 64'h8000_003C) && n < 200) begin
      step();
      n++;
    end
    chk("rstw_setup", 64'(mem_pend && mem_addr == 64'h8000_003C), 64'd1);
    rst = 1'b0;
    step();
    chk("rstw_inst_valid", 64'(inst_valid_o), 64'd0);
    chk("rstw_req_valid", 64'(imem_req_valid_o), 64'd0);
    rst = 1'b1;
    wait_req("rstw_req_timeout");
    chk("rstw_req_addr", imem_addr_o, 64'h8000_0000);

    // Randomized traffic with redirects, stalls and occasional resets.
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      rst              = ($urandom_range(0, 499) != 0);
      imem_req_ready_i = ($urandom_range(0, 3) != 0);
      inst_ready_i     = ($urandom_range(0, 2) != 0);
      trap_valid_i     = 1'b0;
      br_valid_i       = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 2))
          0:       tgt = 64'h8000_0000 + 64'($urandom_range(0, 4095));
          1:       tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
          default: tgt = {$urandom, $urandom};
        endcase
        case ($urandom_range(0, 2))
          0: begin trap_valid_i = 1'b1; trap_pc_i = tgt; end
          1: begin br_valid_i = 1'b1; br_pc_i = tgt; end
          default: begin
            trap_valid_i = 1'b1; trap_pc_i = tgt;
            br_valid_i = 1'b1; br_pc_i = {$urandom, $urandom};
          end
        endcase
      end
      step();
    end
    rst = 1'b1; trap_valid_i = 1'b0; br_valid_i = 1'b0;
    chk("random_progress", 64'(pop_count > 100), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
